mem_access_seq: RTL and testbench
=================================

# mem_access_seq

Memory-stage sequencer for the LC3 pipeline. Sits directly upstream of the memaccess stage and generates the `mem_state` code that stage consumes. It decodes the opcode of the instruction entering the memory stage and steps through the memory phases: indirect-address read, data read or data write. It stalls the upstream pipeline for multi-phase or multi-cycle accesses.

## Interface
Parameters:
- `MEM_WAIT`, default 0: extra wait cycles per memory phase. Each phase lasts 1+MEM_WAIT cycles. Legal range 0..7.

Ports:
- `clock`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-low; sampled on posedge `clock`.
- `instr_valid`  in  1  instruction present at memory-stage input this cycle.
- `opcode`  in  4  IR[15:12] of that instruction.
- `br_taken`  in  1  control flush; cancels an `instr_valid` sampled in the same cycle.
- `mem_state`  out  2  phase code to memaccess: READ=0, WRITE=1, IND=2, IDLE=3.
- `stall`  out  1  freezes fetch/decode/execute while high.
- `mem_done`  out  1  one-cycle pulse in the last cycle of the final phase.
- `ready`  out  1  sequencer accepts `instr_valid` this cycle.

## Operation
Opcode classes (all other opcodes are non-memory):
- LD 0010, LDR 0110 → READ
- ST 0011, STR 0111 → WRITE
- LDI 1010 → IND then READ
- STI 1011 → IND then WRITE

FSM states are S_IDLE, S_IND, S_RD, S_WR. `mem_state` is the registered state code.

Acceptance:
- An instruction is accepted when `ready & instr_valid & ~br_taken`.
- `ready` = state is S_IDLE, or state is S_RD/S_WR with `wait_cnt`==0.
- On acceptance the next state is the first phase of the instruction's class. Non-memory opcodes stay in (or return to) S_IDLE.
- With no acceptance, S_RD/S_WR with `wait_cnt`==0 go to S_IDLE.
- S_IND with `wait_cnt`==0 goes to S_RD (LDI) or S_WR (STI). The class is held in a registered `is_store` bit captured at acceptance.

Wait counter:
- `wait_cnt` is 3 bits. It loads MEM_WAIT on entry to every phase and decrements to 0 while in that phase.

Outputs:
- `stall` = 1 in S_IND always, and in S_RD/S_WR while `wait_cnt`≠0. Otherwise 0.
- `mem_done` = 1 in S_RD/S_WR when `wait_cnt`==0.
- `instr_valid` while `ready`=0 is ignored. Upstream holds the instruction because of `stall`.
- `br_taken` never aborts a phase already in progress.

## Timing
- Reset values: `mem_state`=3 (IDLE), `stall`=0, `mem_done`=0, `ready`=1. Internal `wait_cnt`=0, `is_store`=0.
- Reset low during any phase: the outputs above appear from the next posedge. The in-flight access is dropped, with no `mem_done`.
- Latency, accept to first phase: 1 cycle. Registered `mem_state` changes on the posedge after acceptance.
- Phase lengths:
  - LD/ST: 1+MEM_WAIT cycles.
  - LDI/STI: 2·(1+MEM_WAIT) cycles.
- Back-to-back: a new instruction accepted in the `mem_done` cycle enters its first phase on the next cycle, with no IDLE bubble.
- `stall`, `ready` and `mem_done` are combinational decodes of registered state and `wait_cnt` only. There is no input-to-output combinational path.
- MEM_WAIT=0: S_IND lasts exactly 1 cycle with `stall`=1, and `stall` is never high in S_RD/S_WR.

## Structure
- Shared package `mem_access_seq_pkg`:
  - `mem_state_t` enum (READ=2'd0, WRITE=2'd1, IND=2'd2, IDLE=2'd3).
  - Opcode constants OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI.
  - Function `mem_class(opcode)` returning NONE/RD/WR/IND_RD/IND_WR.
- This package is shared with the memaccess agent's sequence items so that state codes match.
- Single module, no sub-modules. The wait counter stays inline.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `instr_valid`=1 and LD → `mem_state`=3, `stall`=0, `mem_done`=0, `ready`=1 throughout.
- MEM_WAIT=0, LDI then LD back-to-back: `mem_state` sequence 3,2,0,0,3.
  - `stall` is 1 only in the IND cycle.
  - `mem_done` pulses in both READ cycles.
- MEM_WAIT=2, STR: `mem_state`=1 for 3 cycles with `stall`=1,1,0 and `mem_done` on the 3rd cycle.
  - STI instead: 3 cycles of 2, then 3 cycles of 1, with `stall` high for 5 of the 6 cycles.
- Flush: LD with `br_taken`=1 in the same cycle → `mem_state` stays 3 and no `mem_done`.
  - `br_taken` during an STI's IND phase → WRITE still follows.
- Non-memory opcodes ADD 0001 and BR 0000 with `instr_valid`=1 → `mem_state` stays 3, `ready`=1, no `stall`.
- Reset asserted in the second cycle of LDI (MEM_WAIT=1) → next cycle `mem_state`=3 and `stall`=0. No `mem_done` ever appears for that LDI.

Source files
------------

// File: rtl/mem_access_seq_pkg.sv
// Shared definitions for the LC3 memory-stage sequencer: state codes,
// opcode constants and the opcode-to-access-class decode.
package mem_access_seq_pkg;

    // Code values are consumed directly by the memaccess stage.
    typedef enum logic [1:0] {
        READ  = 2'd0,
        WRITE = 2'd1,
        IND   = 2'd2,
        IDLE  = 2'd3
    } mem_state_t;

    typedef enum logic [1:0] {
        S_RD   = 2'd0,
        S_WR   = 2'd1,
        S_IND  = 2'd2,
        S_IDLE = 2'd3
    } seq_state_t;

    typedef enum logic [2:0] {
        NONE,
        RD,
        WR,
        IND_RD,
        IND_WR
    } mem_class_t;

    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_STI = 4'b1011;

    function automatic mem_class_t mem_class(input logic [3:0] opcode);
        mem_class_t cls;
        case (opcode)
            OP_LD, OP_LDR: cls = RD;
            OP_ST, OP_STR: cls = WR;
            OP_LDI:        cls = IND_RD;
            OP_STI:        cls = IND_WR;
            default:       cls = NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mem_access_seq_if.sv
// Handshake between the upstream pipeline (master) and the memory-stage
// sequencer (slave).
interface mem_access_seq_if;
    import mem_access_seq_pkg::*;

    logic       instr_valid;
    logic [3:0] opcode;
    logic       br_taken;
    mem_state_t mem_state;
    logic       stall;
    logic       mem_done;
    logic       ready;

    modport master (
        output instr_valid, opcode, br_taken,
        input  mem_state, stall, mem_done, ready
    );

    modport slave (
        input  instr_valid, opcode, br_taken,
        output mem_state, stall, mem_done, ready
    );

endinterface

// File: rtl/mem_access_seq.sv
// Memory-stage sequencer: steps LC3 loads/stores through indirect, read
// and write phases and stalls upstream while a phase is multi-cycle.
module mem_access_seq
    import mem_access_seq_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic               clock,
    input  logic               reset,
    mem_access_seq_if.slave    bus
);

    localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);

    seq_state_t state;
    logic [2:0] wait_cnt;
    logic       is_store;
    logic       rw_phase;
    logic       wait_zero;
    logic       accept;

    assign rw_phase  = (state == S_RD) || (state == S_WR);
    assign wait_zero = (wait_cnt == '0);

    // Outputs decode registered state only; inputs never reach them combinationally.
    assign bus.ready     = (state == S_IDLE) || (rw_phase && wait_zero);
    assign bus.stall     = (state == S_IND) || (rw_phase && !wait_zero);
    assign bus.mem_done  = rw_phase && wait_zero;
    assign bus.mem_state = mem_state_t'(state);

    assign accept = bus.ready && bus.instr_valid && !bus.br_taken;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            is_store <= 1'b0;
        end else if (accept) begin
            wait_cnt <= WAIT_INIT;
            case (mem_class(bus.opcode))
                RD: begin
                    state    <= S_RD;
                    is_store <= 1'b0;
                end
                WR: begin
                    state    <= S_WR;
                    is_store <= 1'b1;
                end
                IND_RD: begin
                    state    <= S_IND;
                    is_store <= 1'b0;
                end
                IND_WR: begin
                    state    <= S_IND;
                    is_store <= 1'b1;
                end
                default: begin
                    state    <= S_IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end else begin
            case (state)
                S_IND: begin
                    if (wait_zero) begin
                        state    <= is_store ? S_WR : S_RD;
                        wait_cnt <= WAIT_INIT;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                S_RD, S_WR: begin
                    if (wait_zero) begin
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq at MEM_WAIT = 0, 1 and 2.
module tb_mem_access_seq;
    import mem_access_seq_pkg::*;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    mem_access_seq_if b0 ();
    mem_access_seq_if b1 ();
    mem_access_seq_if b2 ();

    mem_access_seq #(.MEM_WAIT(0)) u0 (.clock(clock), .reset(reset), .bus(b0));
    mem_access_seq #(.MEM_WAIT(1)) u1 (.clock(clock), .reset(reset), .bus(b1));
    mem_access_seq #(.MEM_WAIT(2)) u2 (.clock(clock), .reset(reset), .bus(b2));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        reset = 1'b0;
        b0.instr_valid = 1'b1; b0.opcode = OP_LD;  b0.br_taken = 1'b0;
        b1.instr_valid = 1'b1; b1.opcode = OP_LDI; b1.br_taken = 1'b0;
        b2.instr_valid = 1'b1; b2.opcode = OP_STI; b2.br_taken = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            checks += 5;
            if (b0.mem_state !== IDLE) begin failures++; $display("FAIL reset.mem_state cyc %0d: got %0d want 3", k, b0.mem_state); end
            if (b0.stall !== 1'b0) begin failures++; $display("FAIL reset.stall cyc %0d: got %b want 0", k, b0.stall); end
            if (b0.mem_done !== 1'b0) begin failures++; $display("FAIL reset.mem_done cyc %0d: got %b want 0", k, b0.mem_done); end
            if (b0.ready !== 1'b1) begin failures++; $display("FAIL reset.ready cyc %0d: got %b want 1", k, b0.ready); end
            if (b2.mem_state !== IDLE) begin failures++; $display("FAIL reset.w2_state cyc %0d: got %0d want 3", k, b2.mem_state); end
        end
        b0.instr_valid = 1'b0;
        b1.instr_valid = 1'b0;
        b2.instr_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    // W=0: LDI then LD accepted in the LDI's READ cycle.
    task automatic test_ldi_ld();
        logic       v  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0] op [4] = '{OP_LDI, 4'h0, OP_LD, 4'h0};
        logic [1:0] xs [4] = '{2'd2, 2'd0, 2'd0, 2'd3};
        logic       xt [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic       xd [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic       xr [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        checks++;
        if (b0.mem_state !== IDLE) begin failures++; $display("FAIL ldi_ld.start: got %0d want 3", b0.mem_state); end
        for (int k = 0; k < 4; k++) begin
            b0.instr_valid = v[k]; b0.opcode = op[k]; b0.br_taken = 1'b0;
            @(posedge clock); #1;
            checks += 4;
            if (b0.mem_state !== xs[k]) begin failures++; $display("FAIL ldi_ld.mem_state cyc %0d: got %0d want %0d", k, b0.mem_state, xs[k]); end
            if (b0.stall !== xt[k]) begin failures++; $display("FAIL ldi_ld.stall cyc %0d: got %b want %b", k, b0.stall, xt[k]); end
            if (b0.mem_done !== xd[k]) begin failures++; $display("FAIL ldi_ld.mem_done cyc %0d: got %b want %b", k, b0.mem_done, xd[k]); end
            if (b0.ready !== xr[k]) begin failures++; $display("FAIL ldi_ld.ready cyc %0d: got %b want %b", k, b0.ready, xr[k]); end
        end
    endtask

    task automatic test_str_wait2();
        logic       v  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0] xs [4] = '{2'd1, 2'd1, 2'd1, 2'd3};
        logic       xt [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       xd [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic       xr [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 4; k++) begin
            b2.instr_valid = v[k]; b2.opcode = OP_STR; b2.br_taken = 1'b0;
            @(posedge clock); #1;
            checks += 4;
            if (b2.mem_state !== xs[k]) begin failures++; $display("FAIL str_w2.mem_state cyc %0d: got %0d want %0d", k, b2.mem_state, xs[k]); end
            if (b2.stall !== xt[k]) begin failures++; $display("FAIL str_w2.stall cyc %0d: got %b want %b", k, b2.stall, xt[k]); end
            if (b2.mem_done !== xd[k]) begin failures++; $display("FAIL str_w2.mem_done cyc %0d: got %b want %b", k, b2.mem_done, xd[k]); end
            if (b2.ready !== xr[k]) begin failures++; $display("FAIL str_w2.ready cyc %0d: got %b want %b", k, b2.ready, xr[k]); end
        end
    endtask

    task automatic test_sti_wait2();
        logic [1:0] xs [7] = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd3};
        logic       xt [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       xd [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       xr [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 7; k++) begin
            b2.instr_valid = (k == 0); b2.opcode = OP_STI; b2.br_taken = 1'b0;
            @(posedge clock); #1;
            checks += 4;
            if (b2.mem_state !== xs[k]) begin failures++; $display("FAIL sti_w2.mem_state cyc %0d: got %0d want %0d", k, b2.mem_state, xs[k]); end
            if (b2.stall !== xt[k]) begin failures++; $display("FAIL sti_w2.stall cyc %0d: got %b want %b", k, b2.stall, xt[k]); end
            if (b2.mem_done !== xd[k]) begin failures++; $display("FAIL sti_w2.mem_done cyc %0d: got %b want %b", k, b2.mem_done, xd[k]); end
            if (b2.ready !== xr[k]) begin failures++; $display("FAIL sti_w2.ready cyc %0d: got %b want %b", k, b2.ready, xr[k]); end
        end
    endtask

    // W=2: STR then LD offered while busy, LD finally taken in the STR's done cycle.
    task automatic test_back_to_back();
        logic       v  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] op [7] = '{OP_STR, OP_LD, OP_LD, OP_LD, 4'h0, 4'h0, 4'h0};
        logic [1:0] xs [7] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd3};
        logic       xt [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       xd [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 7; k++) begin
            b2.instr_valid = v[k]; b2.opcode = op[k]; b2.br_taken = 1'b0;
            @(posedge clock); #1;
            checks += 3;
            if (b2.mem_state !== xs[k]) begin failures++; $display("FAIL b2b.mem_state cyc %0d: got %0d want %0d", k, b2.mem_state, xs[k]); end
            if (b2.stall !== xt[k]) begin failures++; $display("FAIL b2b.stall cyc %0d: got %b want %b", k, b2.stall, xt[k]); end
            if (b2.mem_done !== xd[k]) begin failures++; $display("FAIL b2b.mem_done cyc %0d: got %b want %b", k, b2.mem_done, xd[k]); end
        end
    endtask

    task automatic test_flush();
        logic       v  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0] op [5] = '{OP_LD, 4'h0, OP_STI, OP_LD, 4'h0};
        logic       br [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0] xs [5] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd3};
        logic       xd [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 5; k++) begin
            b0.instr_valid = v[k]; b0.opcode = op[k]; b0.br_taken = br[k];
            @(posedge clock); #1;
            checks += 2;
            if (b0.mem_state !== xs[k]) begin failures++; $display("FAIL flush.mem_state cyc %0d: got %0d want %0d", k, b0.mem_state, xs[k]); end
            if (b0.mem_done !== xd[k]) begin failures++; $display("FAIL flush.mem_done cyc %0d: got %b want %b", k, b0.mem_done, xd[k]); end
        end
        b0.br_taken = 1'b0;
    endtask

    task automatic test_non_mem();
        logic [3:0] op [4] = '{4'b0001, 4'b0000, 4'b1100, 4'b0001};
        for (int k = 0; k < 4; k++) begin
            b0.instr_valid = 1'b1; b0.opcode = op[k]; b0.br_taken = 1'b0;
            @(posedge clock); #1;
            checks += 3;
            if (b0.mem_state !== IDLE) begin failures++; $display("FAIL non_mem.mem_state cyc %0d: got %0d want 3", k, b0.mem_state); end
            if (b0.ready !== 1'b1) begin failures++; $display("FAIL non_mem.ready cyc %0d: got %b want 1", k, b0.ready); end
            if (b0.stall !== 1'b0) begin failures++; $display("FAIL non_mem.stall cyc %0d: got %b want 0", k, b0.stall); end
        end
        b0.instr_valid = 1'b0;
    endtask

    // W=1: reset lands in the second IND cycle of an LDI.
    task automatic test_reset_mid_ldi();
        b1.instr_valid = 1'b1; b1.opcode = OP_LDI; b1.br_taken = 1'b0;
        @(posedge clock); #1;
        b1.instr_valid = 1'b0;
        checks += 2;
        if (b1.mem_state !== IND) begin failures++; $display("FAIL rst_ldi.ind1_state: got %0d want 2", b1.mem_state); end
        if (b1.stall !== 1'b1) begin failures++; $display("FAIL rst_ldi.ind1_stall: got %b want 1", b1.stall); end
        @(posedge clock); #1;
        checks++;
        if (b1.mem_state !== IND) begin failures++; $display("FAIL rst_ldi.ind2_state: got %0d want 2", b1.mem_state); end
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        checks += 4;
        if (b1.mem_state !== IDLE) begin failures++; $display("FAIL rst_ldi.mem_state: got %0d want 3", b1.mem_state); end
        if (b1.stall !== 1'b0) begin failures++; $display("FAIL rst_ldi.stall: got %b want 0", b1.stall); end
        if (b1.ready !== 1'b1) begin failures++; $display("FAIL rst_ldi.ready: got %b want 1", b1.ready); end
        if (b1.mem_done !== 1'b0) begin failures++; $display("FAIL rst_ldi.mem_done: got %b want 0", b1.mem_done); end
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            checks += 2;
            if (b1.mem_done !== 1'b0) begin failures++; $display("FAIL rst_ldi.late_done cyc %0d: got %b want 0", k, b1.mem_done); end
            if (b1.mem_state !== IDLE) begin failures++; $display("FAIL rst_ldi.late_state cyc %0d: got %0d want 3", k, b1.mem_state); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        test_reset();
        test_ldi_ld();
        test_str_wait2();
        test_sti_wait2();
        test_back_to_back();
        test_flush();
        test_non_mem();
        test_reset_mid_ldi();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
